tft43_fill_ctrl: RTL and testbench



---
 rtl/tft43_fill_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_tft43_fill_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tft43_fill_ctrl.sv
// Purpose : command sequencer for the TFT 4.3'' command module; runs LCD power-up (reset, register init)
//           and solid rectangle fills (column window, page window, GRAM start, one data write per pixel).
// Latency : a start is accepted on the edge it is sampled; busy rises the next cycle, done pulses once at the end.
// Backpressure: each command is held (lcd_en=1, trigger/data stable) until lcd_done; starts seen while busy are dropped.
// Ports   : clk/rst (sync, active-high); init_start/fill_start + x/y/color request; busy/done/err/initialized status;
//           lcd_en/lcd_trigger/lcd_data1/lcd_data2 command outputs; lcd_done completion pulse from the command module.
module tft43_fill_ctrl #(
  parameter int H_RES = 800,
  parameter int V_RES = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_start,
  input  logic        fill_start,
  input  logic [15:0] x_start,
  input  logic [15:0] x_end,
  input  logic [15:0] y_start,
  input  logic [15:0] y_end,
  input  logic [15:0] color,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        initialized,
  output logic        lcd_en,
  output logic [3:0]  lcd_trigger,
  output logic [15:0] lcd_data1,
  output logic [15:0] lcd_data2,
  input  logic        lcd_done
);

  localparam logic [15:0] H_LIM = 16'(H_RES);
  localparam logic [15:0] V_LIM = 16'(V_RES);

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_INIT, S_CHECK, S_COL, S_PAGE, S_GRAM, S_PIX, S_GAP, S_FIN
  } state_t;

  state_t      state_q, state_d;
  state_t      nxt_q, nxt_d;       // command state to enter when GAP ends
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        init_q, init_d;
  logic        en_q, en_d;
  logic [3:0]  trig_q, trig_d;
  logic [15:0] d1_q, d1_d;
  logic [15:0] d2_q, d2_d;
  logic [15:0] ys_q, ys_d;
  logic [15:0] ye_q, ye_d;
  logic [15:0] color_q, color_d;
  logic [15:0] xlen_q, xlen_d;     // x_end - x_start, last col_cnt value
  logic [15:0] ylen_q, ylen_d;     // y_end - y_start, last row_cnt value
  logic [15:0] col_cnt_q, col_cnt_d;
  logic [15:0] row_cnt_q, row_cnt_d;
  logic        bad_req;

  assign bad_req = !init_q || (x_end < x_start) || (y_end < y_start) ||
                   (x_end >= H_LIM) || (y_end >= V_LIM);

  always_comb begin
    state_d   = state_q;
    nxt_d     = nxt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    init_d    = init_q;
    en_d      = en_q;
    trig_d    = trig_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    ys_d      = ys_q;
    ye_d      = ye_q;
    color_d   = color_q;
    xlen_d    = xlen_q;
    ylen_d    = ylen_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;

    // Commands are loaded on the same edge that raises lcd_en, so trigger/data
    // are valid for the whole enable window.
    unique case (state_q)
      S_IDLE: begin
        if (init_start) begin
          state_d = S_RST;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          en_d    = 1'b1;
          trig_d  = 4'd1;
          d1_d    = 16'h0000;
          d2_d    = 16'h0000;
        end else if (fill_start) begin
          state_d = S_CHECK;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_RST: begin
        if (lcd_done) begin
          en_d    = 1'b0;
          nxt_d   = S_INIT;
          state_d = S_GAP;
        end
      end
      S_INIT: begin
        if (lcd_done) begin
          en_d    = 1'b0;
          init_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_CHECK: begin
        ys_d      = y_start;
        ye_d      = y_end;
        color_d   = color;
        xlen_d    = x_end - x_start;
        ylen_d    = y_end - y_start;
        col_cnt_d = 16'h0000;
        row_cnt_d = 16'h0000;
        if (bad_req) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_COL;
          en_d    = 1'b1;
          trig_d  = 4'd3;
          d1_d    = x_start;
          d2_d    = x_end;
        end
      end
      S_COL, S_PAGE, S_GRAM: begin
        if (lcd_done) begin
          en_d    = 1'b0;
          state_d = S_GAP;
          nxt_d   = (state_q == S_COL)  ? S_PAGE :
                    (state_q == S_PAGE) ? S_GRAM : S_PIX;
        end
      end
      S_PIX: begin
        if (lcd_done) begin
          en_d = 1'b0;
          if (col_cnt_q == xlen_q && row_cnt_q == ylen_q) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            // Column counter wraps to the next row after the last column.
            if (col_cnt_q == xlen_q) begin
              col_cnt_d = 16'h0000;
              row_cnt_d = row_cnt_q + 16'd1;
            end else begin
              col_cnt_d = col_cnt_q + 16'd1;
            end
            nxt_d   = S_PIX;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        // One idle cycle lets the command module's step counter return to 0.
        state_d = nxt_q;
        en_d    = 1'b1;
        unique case (nxt_q)
          S_INIT: begin trig_d = 4'd2; d1_d = 16'h0000; d2_d = 16'h0000; end
          S_PAGE: begin trig_d = 4'd4; d1_d = ys_q;     d2_d = ye_q;     end
          S_GRAM: begin trig_d = 4'd5; d1_d = 16'h0001; d2_d = 16'h0000; end
          default: begin trig_d = 4'd7; d1_d = color_q; d2_d = 16'h0000; end
        endcase
      end
      S_FIN: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      nxt_q     <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      init_q    <= 1'b0;
      en_q      <= 1'b0;
      trig_q    <= 4'd0;
      d1_q      <= 16'h0000;
      d2_q      <= 16'h0000;
      ys_q      <= 16'h0000;
      ye_q      <= 16'h0000;
      color_q   <= 16'h0000;
      xlen_q    <= 16'h0000;
      ylen_q    <= 16'h0000;
      col_cnt_q <= 16'h0000;
      row_cnt_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      nxt_q     <= nxt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      init_q    <= init_d;
      en_q      <= en_d;
      trig_q    <= trig_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      ys_q      <= ys_d;
      ye_q      <= ye_d;
      color_q   <= color_d;
      xlen_q    <= xlen_d;
      ylen_q    <= ylen_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign initialized = init_q;
  assign lcd_en      = en_q;
  assign lcd_trigger = trig_q;
  assign lcd_data1   = d1_q;
  assign lcd_data2   = d2_q;

endmodule

// File: tb/tb_tft43_fill_ctrl.sv
// Testbench for tft43_fill_ctrl: a command-module model answers each lcd_en rise with
// a one-cycle lcd_done three cycles later; a monitor logs every issued command and the
// idle gap before it. A table of requests is replayed in order, then a reset-abort sequence.
module tb_tft43_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_start = 1'b0;
  logic        fill_start = 1'b0;
  logic [15:0] x_start = '0, x_end = '0, y_start = '0, y_end = '0, color = '0;
  logic        busy, done, err, initialized, lcd_en;
  logic [3:0]  lcd_trigger;
  logic [15:0] lcd_data1, lcd_data2;
  logic        lcd_done = 1'b0;

  always #50 clk = ~clk;

  tft43_fill_ctrl #(.H_RES(800), .V_RES(480)) dut (
    .clk(clk), .rst(rst), .init_start(init_start), .fill_start(fill_start),
    .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end), .color(color),
    .busy(busy), .done(done), .err(err), .initialized(initialized),
    .lcd_en(lcd_en), .lcd_trigger(lcd_trigger), .lcd_data1(lcd_data1), .lcd_data2(lcd_data2),
    .lcd_done(lcd_done)
  );

  typedef struct packed {
    logic [3:0]  t;
    logic [15:0] d1;
    logic [15:0] d2;
  } cmd_t;

  typedef struct {
    logic        init;
    logic        fill;
    logic [15:0] xs, xe, ys, ye, col;
    logic        eerr;
    int          npix;
    logic        einit;
    logic        poke;
  } vec_t;

  cmd_t cmd_q[$];
  int   gap_q[$];
  cmd_t cur = '0;
  logic en_prev = 1'b0;
  int   low_run = 0;
  int   dly = 0;
  int   done_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int count_pix();
    int c = 0;
    foreach (cmd_q[i]) if (cmd_q[i].t == 4'd7) c++;
    return c;
  endfunction

  // Command-module model and monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      en_prev  = 1'b0;
      dly      = 0;
      lcd_done = 1'b0;
      low_run  = 0;
    end else begin
      if (lcd_en && !en_prev) begin
        cur = {lcd_trigger, lcd_data1, lcd_data2};
        cmd_q.push_back(cur);
        if (cmd_q.size() > 1) gap_q.push_back(low_run);
        dly = 3;
      end else begin
        if (lcd_en) chk("cmd_hold", {28'd0, lcd_trigger, lcd_data1, lcd_data2}, {28'd0, cur});
        if (dly > 0) dly--;
      end
      lcd_done = (dly == 1) && lcd_en;
      low_run  = lcd_en ? 0 : low_run + 1;
      en_prev  = lcd_en;
      if (done) done_cnt++;
    end
  end

  task automatic run_row(input vec_t v, input int idx);
    int   n;
    int   dc;
    bit   poked;
    int   ncmd;
    cmd_q.delete();
    gap_q.delete();
    chk($sformatf("r%0d idle_busy", idx), busy, 1'b0);
    x_start = v.xs; x_end = v.xe; y_start = v.ys; y_end = v.ye; color = v.col;
    init_start = v.init;
    fill_start = v.fill;
    dc = done_cnt;
    @(negedge clk);
    init_start = 1'b0;
    fill_start = 1'b0;
    chk($sformatf("r%0d busy_rise", idx), busy, 1'b1);
    n = 0;
    poked = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      fill_start = 1'b0;
      if (v.poke && !poked && count_pix() >= 2) begin
        // Start while busy with different coordinates: must change nothing.
        fill_start = 1'b1;
        x_start = 16'd0; x_end = 16'd799; y_start = 16'd0; y_end = 16'd479; color = 16'h1234;
        poked = 1;
      end
    end
    fill_start = 1'b0;
    chk($sformatf("r%0d done_seen", idx), n < 3000, 1'b1);
    chk($sformatf("r%0d err", idx), err, v.eerr);
    chk($sformatf("r%0d busy_at_done", idx), busy, 1'b1);
    chk($sformatf("r%0d initialized", idx), initialized, v.einit);
    @(negedge clk);
    chk($sformatf("r%0d done_one_cycle", idx), done, 1'b0);
    chk($sformatf("r%0d busy_fall", idx), busy, 1'b0);
    chk($sformatf("r%0d done_pulses", idx), done_cnt - dc, 1);
    ncmd = cmd_q.size();
    if (v.init) begin
      chk($sformatf("r%0d ncmd", idx), ncmd, 2);
      if (ncmd >= 2) begin
        chk($sformatf("r%0d trig_rst", idx), cmd_q[0].t, 4'd1);
        chk($sformatf("r%0d trig_init", idx), cmd_q[1].t, 4'd2);
      end
    end else if (v.eerr) begin
      chk($sformatf("r%0d ncmd", idx), ncmd, 0);
    end else begin
      chk($sformatf("r%0d ncmd", idx), ncmd, 3 + v.npix);
      chk($sformatf("r%0d npix", idx), count_pix(), v.npix);
      if (ncmd >= 3) begin
        chk($sformatf("r%0d col", idx), cmd_q[0], {4'd3, v.xs, v.xe});
        chk($sformatf("r%0d page", idx), cmd_q[1], {4'd4, v.ys, v.ye});
        chk($sformatf("r%0d gram_t", idx), cmd_q[2].t, 4'd5);
        chk($sformatf("r%0d gram_d1", idx), cmd_q[2].d1, 16'h0001);
      end
      for (int i = 3; i < ncmd; i++) begin
        chk($sformatf("r%0d pix%0d_t", idx, i - 3), cmd_q[i].t, 4'd7);
        chk($sformatf("r%0d pix%0d_d1", idx, i - 3), cmd_q[i].d1, v.col);
      end
    end
    foreach (gap_q[i]) chk($sformatf("r%0d gap%0d", idx, i), gap_q[i], 1);
  endtask

  initial begin
    int n;
    int dc;
    //          init  fill  xs      xe      ys      ye      color     err   npix einit poke
    vecs[0] = '{1'b0, 1'b1, 16'd0,  16'd9,  16'd0,  16'd9,  16'h0000, 1'b1, 0,   1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'd0,  16'd0,  16'd0,  16'd0,  16'h0000, 1'b0, 0,   1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'd10, 16'd12, 16'd20, 16'd21, 16'hF800, 1'b0, 6,   1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'd0,  16'd800,16'd0,  16'd0,  16'h0000, 1'b1, 0,   1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 16'd799,16'd799,16'd479,16'd479,16'h001F, 1'b0, 1,   1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 16'd5,  16'd4,  16'd0,  16'd0,  16'h0000, 1'b1, 0,   1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 16'd0,  16'd0,  16'd3,  16'd2,  16'h0000, 1'b1, 0,   1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 16'd0,  16'd0,  16'd0,  16'd480,16'h0000, 1'b1, 0,   1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 16'd0,  16'd1,  16'd0,  16'd0,  16'h0000, 1'b0, 0,   1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 16'd0,  16'd2,  16'd0,  16'd1,  16'h07E0, 1'b0, 6,   1'b1, 1'b1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst initialized", initialized, 1'b0);
    chk("rst lcd_en", lcd_en, 1'b0);
    chk("rst trigger", lcd_trigger, 4'd0);
    chk("rst data1", lcd_data1, 16'd0);
    chk("rst data2", lcd_data2, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 10; r++) begin
      run_row(vecs[r], r);
      @(negedge clk);
    end

    // Reset during the third pixel write of a 4x1 fill.
    cmd_q.delete();
    gap_q.delete();
    x_start = 16'd0; x_end = 16'd3; y_start = 16'd0; y_end = 16'd0; color = 16'hABCD;
    fill_start = 1'b1;
    @(negedge clk);
    fill_start = 1'b0;
    n = 0;
    while (count_pix() < 3 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort reached_pix3", n < 500, 1'b1);
    chk("abort en_before", lcd_en, 1'b1);
    rst = 1'b1;
    dc = done_cnt;
    @(negedge clk);
    chk("abort lcd_en", lcd_en, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort initialized", initialized, 1'b0);
    chk("abort done", done, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort no_done", done_cnt - dc, 0);
    chk("abort no_more_cmds", cmd_q.size(), 6);
    chk("abort idle_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
